// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU execution controller and
// its iterative shifter.
//   - opcode (alu_op) and function (alu_funct) field encodings
//   - controller FSM state enum
//   - shift-kind encoding (matches alu_funct of the shift opcode)
package alu_pkg;

  localparam logic [4:0] OP_ALU   = 5'b11011;  // register-register group, funct selects
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b10001;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;
  localparam logic [4:0] OP_SHIFT = 5'b11010;
  localparam logic [4:0] OP_HALT  = 5'b00000;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_ROL = 2'b00,
    SH_SLL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } shift_kind_t;

endpackage

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter: bit-serial shifter, one bit position per clock.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load data_in/shamt/kind (only issued with shamt > 0)
//   kind        ROL / SLL / ROR / SRL
//   data_in     value to shift
//   shamt       number of single-bit steps
//   data        shift register contents (final once done has pulsed)
//   done        one-cycle pulse in the cycle after the last step
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  shift_kind_t                kind,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic [WIDTH-1:0]           data,
  output logic                       done
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [SHAMT_W-1:0] cnt;
  shift_kind_t        kind_q;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input shift_kind_t k);
    case (k)
      SH_ROL:  return {v[WIDTH-2:0], v[WIDTH-1]};
      SH_SLL:  return {v[WIDTH-2:0], 1'b0};
      SH_ROR:  return {v[0], v[WIDTH-1:1]};
      SH_SRL:  return {1'b0, v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  // The register stops moving once the counter is 0, so data keeps the
  // final value until the controller has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      cnt    <= '0;
      kind_q <= SH_ROL;
      done   <= 1'b0;
    end else if (start) begin
      data   <= data_in;
      cnt    <= shamt;
      kind_q <= kind;
      done   <= 1'b0;
    end else if (cnt != '0) begin
      data   <= step1(data, kind_q);
      cnt    <= cnt - CNT_ONE;
      done   <= (cnt == CNT_ONE);
    end else begin
      done   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: single-issue ALU execution controller.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (alu_op, alu_funct, a, b)
//   out_valid / out_ready result handshake (result, cout, ofl, zero, illegal)
//   busy                  FSM is not IDLE (shift in flight or shift result held)
// Non-shift ops (and shifts by 0) go through a one-entry capture stage and
// appear one edge after acceptance. Shifts by n > 0 are loaded straight into
// the iterative shifter and appear n+1 edges after acceptance.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [1:0]       alu_funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ofl,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t state, state_nx;

  logic out_free, accept, shift_start;
  logic load_p0, load_sh, sh_pend;

  logic [4:0]              op_p0;
  logic [1:0]              funct_p0;
  logic [WIDTH-1:0]        a_p0, b_p0;
  logic                    vld_p0;
  logic signed [WIDTH-1:0] a_s_p0, b_s_p0;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_ofl, sub_ofl;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ofl, alu_ill;

  logic [WIDTH-1:0] sh_data;
  logic             sh_done;

  assign out_free    = !out_valid || out_ready;
  assign in_ready    = (state == ST_IDLE) && out_free;
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && (alu_op == OP_SHIFT) && (b[SHAMT_W-1:0] != '0);
  assign busy        = (state != ST_IDLE);

  // The capture stage is empty whenever a shift is in flight, so the two
  // output sources never compete.
  assign load_p0 = vld_p0 && out_free;
  assign load_sh = out_free && (((state == ST_SHIFT) && sh_done) ||
                                ((state == ST_HOLD) && sh_pend));

  alu_iter_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (shift_start),
    .kind    (shift_kind_t'(alu_funct)),
    .data_in (a),
    .shamt   (b[SHAMT_W-1:0]),
    .data    (sh_data),
    .done    (sh_done)
  );

  // ---- stage p0: request capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
    end else if (accept && !shift_start) begin
      vld_p0 <= 1'b1;
    end else if (out_free) begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !shift_start) begin
      op_p0    <= alu_op;
      funct_p0 <= alu_funct;
      a_p0     <= a;
      b_p0     <= b;
    end
  end

  assign a_s_p0 = $signed(a_p0);
  assign b_s_p0 = $signed(b_p0);

  // Subtraction is b - a formed as ~a + b + 1: carry-out 1 means no borrow.
  assign add_sum = {1'b0, a_p0} + {1'b0, b_p0};
  assign sub_sum = {1'b0, ~a_p0} + {1'b0, b_p0} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ofl = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (add_sum[WIDTH-1] != a_p0[WIDTH-1]);
  assign sub_ofl = (a_p0[WIDTH-1] != b_p0[WIDTH-1]) && (sub_sum[WIDTH-1] != b_p0[WIDTH-1]);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ofl  = 1'b0;
    alu_ill  = 1'b0;
    case (op_p0)
      OP_ALU: begin
        case (funct_p0)
          FN_ADD:  begin alu_res = add_sum[WIDTH-1:0]; alu_cout = add_sum[WIDTH]; alu_ofl = add_ofl; end
          FN_SUB:  begin alu_res = sub_sum[WIDTH-1:0]; alu_cout = sub_sum[WIDTH]; alu_ofl = sub_ofl; end
          FN_XOR:  alu_res = a_p0 ^ b_p0;
          FN_ANDN: alu_res = a_p0 & ~b_p0;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI: begin alu_res = add_sum[WIDTH-1:0]; alu_cout = add_sum[WIDTH]; alu_ofl = add_ofl; end
      OP_SUBI: begin alu_res = sub_sum[WIDTH-1:0]; alu_cout = sub_sum[WIDTH]; alu_ofl = sub_ofl; end
      OP_LBI:  alu_res = b_p0;
      OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (a_p0 == b_p0)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s_p0 < b_s_p0)};
      OP_SLE:  alu_res = {{(WIDTH-1){1'b0}}, (a_s_p0 <= b_s_p0)};
      OP_SCO: begin
        alu_res  = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
        alu_cout = add_sum[WIDTH];
        alu_ofl  = add_ofl;
      end
      OP_SHIFT: alu_res = a_p0;  // only shift-by-0 reaches this stage
      OP_HALT:  alu_res = '0;
      default:  alu_ill = 1'b1;
    endcase
  end

  // ---- stage p1: registered result and flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ofl       <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_p0) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      cout      <= alu_cout;
      ofl       <= alu_ofl;
      zero      <= (alu_res == '0);
      illegal   <= alu_ill;
    end else if (load_sh) begin
      out_valid <= 1'b1;
      result    <= sh_data;
      cout      <= 1'b0;
      ofl       <= 1'b0;
      zero      <= (sh_data == '0);
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A shift can finish while an earlier single-cycle result is still
  // stalled at the output; remember it and load it once the output frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pend <= 1'b0;
    end else if ((state == ST_SHIFT) && sh_done && !out_free) begin
      sh_pend <= 1'b1;
    end else if (load_sh) begin
      sh_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (shift_start) state_nx = ST_SHIFT;
      ST_SHIFT: if (sh_done) state_nx = ST_HOLD;
      ST_HOLD:  if (out_valid && out_ready && !sh_pend) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

endmodule
